// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

    // Supervisor states; encodings are visible on state_dbg.
    typedef enum logic [2:0] {
        PllReset  = 3'd0,
        WaitLock  = 3'd1,
        Stabilize = 3'd2,
        Run       = 3'd3,
        Fault     = 3'd4
    } pll_state_e;

    localparam int unsigned RelockCountWidth = 8;

    // Largest of three values; sizes the shared cycle counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the async level through two flops; both clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock, then releases the PLL-domain
// reset. Repeated lock timeouts park the block in a sticky fault state.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 10,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned STABLE_CYCLES       = 1024,
    parameter int unsigned MAX_RETRIES         = 4
) (
    input  logic                        refclk,
    input  logic                        rst,
    input  logic                        locked,
    input  logic                        clear_fault,
    output logic                        pll_rst,
    output logic                        sys_rst,
    output logic                        ready,
    output logic                        fault,
    output logic [RelockCountWidth-1:0] relock_count,
    output logic [2:0]                  state_dbg
);

    localparam int unsigned MaxCycles = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                             STABLE_CYCLES);
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
    localparam int unsigned RetryW    = $clog2(MAX_RETRIES + 1);

    localparam logic [CntW-1:0]   RstLast     = CntW'(RST_PULSE_CYCLES - 1);
    localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0]   StableLast  = CntW'(STABLE_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

    logic locked_s;
    logic clear_s;

    pll_state_e                  state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [RetryW-1:0]           retry_q, retry_d;
    logic [RetryW-1:0]           retry_inc;
    logic [RelockCountWidth-1:0] relock_q, relock_d;
    logic                        pll_rst_q, pll_rst_d;
    logic                        sys_rst_q, sys_rst_d;
    logic                        ready_q, ready_d;
    logic                        fault_q, fault_d;

    bit_sync u_sync_locked (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    bit_sync u_sync_clear (
        .clk (refclk),
        .rst (rst),
        .d   (clear_fault),
        .q   (clear_s)
    );

    assign retry_inc = retry_q + RetryW'(1);

    // Next-state, counters and output decode from the next state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        relock_d = relock_q;

        case (state_q)
            PllReset: begin
                if (cnt_q == RstLast) state_d = WaitLock;
                else                  cnt_d   = cnt_q + CntW'(1);
            end
            WaitLock: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s) begin
                    state_d = Stabilize;
                end else if (cnt_q == TimeoutLast) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RetryMax) ? Fault : PllReset;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            Stabilize: begin
                if (!locked_s) begin
                    state_d = WaitLock;
                end else if (cnt_q == StableLast) begin
                    state_d = Run;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            Run: begin
                if (!locked_s) begin
                    state_d = PllReset;
                    if (relock_q != '1) relock_d = relock_q + RelockCountWidth'(1);
                end
            end
            Fault: begin
                if (clear_s) begin
                    state_d = PllReset;
                    retry_d = '0;
                end
            end
            default: state_d = PllReset;
        endcase

        if (state_d != state_q) cnt_d = '0;

        pll_rst_d = (state_d == PllReset) || (state_d == Fault);
        sys_rst_d = (state_d != Run);
        ready_d   = (state_d == Run);
        fault_d   = (state_d == Fault);
    end

    // State, counters and registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= PllReset;
            cnt_q     <= '0;
            retry_q   <= '0;
            relock_q  <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            relock_q  <= relock_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_rst      = sys_rst_q;
    assign ready        = ready_q;
    assign fault        = fault_q;
    assign relock_count = relock_q;
    assign state_dbg    = state_q;

endmodule
